// File: rtl/mips_unified_memory_if.sv
// rtl/mips_unified_memory_if.sv - core-side memory bus between the MIPS core and the unified memory
interface mips_unified_memory_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     MEM_WS;
  logic [1:0]               RAM_SEL;
  logic [ADDRESS_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0]    WDATA;
  logic [DATA_WIDTH-1:0]    DATA;
  logic                     INIT_BUSY;

  modport master (
    output MEM_WS, RAM_SEL, Addr, WDATA,
    input  DATA, INIT_BUSY
  );

  modport slave (
    input  MEM_WS, RAM_SEL, Addr, WDATA,
    output DATA, INIT_BUSY
  );
endinterface

// File: rtl/mips_unified_memory.sv
// rtl/mips_unified_memory.sv - unified byte-addressed memory with clear sequencer, MMIO output and store bookkeeping
module mips_unified_memory #(
  parameter int                       ADDRESS_WIDTH  = 32,
  parameter int                       DATA_WIDTH     = 32,
  parameter int                       DEPTH_WORDS    = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] MMIO_ADDR      = 32'hFFFF_FFF0,
  parameter bit                       CLEAR_ON_RESET = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  mips_unified_memory_if.slave  bus,
  output logic                  ALIGN_ERR,
  output logic [DATA_WIDTH-1:0] MMIO_OUT,
  output logic [15:0]           STORE_CNT
);
  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clr_idx;
  logic                  init_busy, clear_we, run;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx;
  logic                  mmio_hit, is_word, is_half, is_byte;
  logic                  misaligned, store_req, store_ok;
  logic [DATA_WIDTH-1:0] src_word, wr_word, rd_data;
  logic [15:0]           half_lane;
  logic [7:0]            byte_lane;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_CLEAR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && (!CLEAR_ON_RESET || clr_idx == IDX_LAST))
      state_d = ST_RUN;
  end

  always_comb begin
    init_busy = (state_q == ST_CLEAR);
    run       = (state_q == ST_RUN);
    clear_we  = (state_q == ST_CLEAR) && CLEAR_ON_RESET;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)          clr_idx <= '0;
    else if (clear_we) clr_idx <= clr_idx + IDX_ONE;
  end

  // Upper address bits alias onto the array except for the single MMIO word.
  assign idx        = bus.Addr[IDX_W+1:2];
  assign mmio_hit   = (bus.Addr[ADDRESS_WIDTH-1:2] == MMIO_ADDR[ADDRESS_WIDTH-1:2]);
  assign is_half    = (bus.RAM_SEL == 2'b01);
  assign is_byte    = (bus.RAM_SEL == 2'b10);
  assign is_word    = !is_half && !is_byte;
  assign misaligned = (is_word && bus.Addr[1:0] != 2'b00) || (is_half && bus.Addr[0]) ||
                      (mmio_hit && !is_word);
  assign store_req  = run && bus.MEM_WS;
  assign store_ok   = store_req && !misaligned;

  assign src_word  = mmio_hit ? MMIO_OUT : mem[idx];
  assign half_lane = bus.Addr[1] ? src_word[31:16] : src_word[15:0];
  assign byte_lane = 8'(src_word >> {bus.Addr[1:0], 3'b000});

  // Misaligned reads fall back to the aligned-down lane since fetches always read.
  always_comb begin
    rd_data = '0;
    if (run) begin
      if (is_half)      rd_data = DATA_WIDTH'(half_lane);
      else if (is_byte) rd_data = DATA_WIDTH'(byte_lane);
      else              rd_data = src_word;
    end
  end

  assign bus.DATA      = rd_data;
  assign bus.INIT_BUSY = init_busy;

  always_comb begin
    wr_word = mem[idx];
    if (is_word) begin
      wr_word = bus.WDATA;
    end else if (is_half) begin
      if (bus.Addr[1]) wr_word[31:16] = bus.WDATA[15:0];
      else             wr_word[15:0]  = bus.WDATA[15:0];
    end else begin
      wr_word[{bus.Addr[1:0], 3'b000} +: 8] = bus.WDATA[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (clear_we)                   mem[clr_idx] <= '0;
    else if (store_ok && !mmio_hit) mem[idx]     <= wr_word;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALIGN_ERR <= 1'b0;
      MMIO_OUT  <= '0;
      STORE_CNT <= '0;
    end else begin
      if (store_req && misaligned)             ALIGN_ERR <= 1'b1;
      if (store_ok && mmio_hit)                MMIO_OUT  <= bus.WDATA;
      if (store_ok && STORE_CNT != 16'hFFFF)   STORE_CNT <= STORE_CNT + 16'd1;
    end
  end
endmodule
